muldiv_issue: RTL
=================

// Module: muldiv_issue
// PURPOSE
//  EX-stage issuer for the multicycle M-extension unit; it drives the unit's
//  op_valid/op_ready/op_stall handshake from the initiator side.
//  - Accepts one M-op from decode (valid/ready).
//  - Holds op/op1/op2 stable and asserts fu_op_valid until the unit returns fu_op_ready.
//  - Captures the result into a one-entry writeback buffer and offers it to writeback (valid/ready).
//  - Drains in-flight ops on pipeline flush and runs a watchdog.
// PARAMETERS
//  XLEN     32   operand/result width
//  RD_W     5    destination register index width
//  TIMEOUT  127  cycles in ISSUE/DRAIN (non-stalled) before err is set; 0 disables
// PORTS
//  clk          in   1     clock
//  rstn         in   1     reset; one clock, reset is synchronous and active-low
//  flush        in   1     kill younger work (in-flight op + same-cycle in_valid)
//  in_valid     in   1     decode presents M-op
//  in_ready     out  1     issuer accepts M-op this cycle
//  in_op        in   3     func3 (MUL..REMU)
//  in_op1       in   XLEN  rs1 value
//  in_op2       in   XLEN  rs2 value
//  in_rd        in   RD_W  destination register
//  fu_op_valid  out  1     request to unit; held high until fu_op_ready
//  fu_op_ready  in   1     unit completes; fu_op_out valid this cycle
//  fu_op_stall  out  1     freeze unit (no completion allowed)
//  fu_op        out  3     latched func3
//  fu_op1       out  XLEN  latched rs1
//  fu_op2       out  XLEN  latched rs2
//  fu_op_out    in   XLEN  unit result, sampled only when fu_op_ready
//  wb_valid     out  1     buffered result available
//  wb_ready     in   1     writeback consumes result
//  wb_rd        out  RD_W  destination of buffered result
//  wb_data      out  XLEN  buffered result
//  busy         out  1     state != IDLE
//  err          out  1     sticky watchdog expiry
// BEHAVIOUR
//  Reset values (rstn==0 at clk edge):
//   - state=IDLE; fu_op_valid=0; fu_op/op1/op2=0; wb_valid=0; wb_rd/wb_data=0; err=0; wdog=0.
//  States:
//   - IDLE:  in_ready = ~flush.
//            On in_valid && in_ready: latch op/op1/op2/rd, go to ISSUE.
//   - ISSUE: fu_op_valid=1; latched operands must not change.
//            On fu_op_ready && ~flush: write fu_op_out/rd into the wb buffer, go to IDLE.
//            On flush && ~fu_op_ready: go to DRAIN.
//            On flush && fu_op_ready: discard the result, go to IDLE.
//   - DRAIN: fu_op_valid=1 with operands held, because the unit cannot abort.
//            On fu_op_ready: discard the result, go to IDLE. Further flush is ignored.
//  Stall:
//   - fu_op_stall = (state==ISSUE) && wb_valid && ~wb_ready. The buffer is full, so the unit must not complete.
//   - fu_op_stall = 0 in IDLE and DRAIN.
//  Writeback buffer:
//   - wb_valid sets the cycle after capture and clears on wb_valid && wb_ready.
//   - Capture with simultaneous wb_ready: old entry leaves and new entry loads; wb_valid stays 1.
//   - flush does NOT touch the wb buffer (buffered result is older than the flush point).
//  Latency:
//   - in accept at T -> fu_op_valid at T+1.
//   - fu_op_ready at Tr -> wb_valid at Tr+1.
//   - Next op acceptable at Tr+1 (in_ready only in IDLE; no overlap of FU ops).
//  Watchdog:
//   - wdog counts cycles in ISSUE/DRAIN with fu_op_stall=0.
//   - Clears on entry to IDLE.
//   - wdog==TIMEOUT sets err (sticky until reset); state is unaffected; counter saturates.
//  Other rules:
//   - fu_op_ready seen in IDLE is ignored (protocol violation; assert in sim).
//   - Reset mid-ISSUE returns to IDLE with fu_op_valid=0. The unit shares rstn and resets with it.
// STRUCTURE
//  - muldiv_pkg: state_t {IDLE=2'b00, ISSUE=2'b01, DRAIN=2'b10}; func3 localparams MUL..REMU (3'b000..3'b111).
//  - Sub-module wb_buf_1e: one-entry valid/ready register slice, XLEN+RD_W wide; used for the result buffer.
//  - Control FSM, operand latch and watchdog stay inline.
// TESTING
//  1. MUL op1=7 op2=6 rd=3 with real muldiv, wb_ready=1
//     -> exactly one wb_valid pulse, wb_data=42, wb_rd=3; busy low afterwards.
//  2. MULH op1=32'h8000_0000 op2=32'h8000_0000
//     -> wb_data=32'h4000_0000; DIVU 100/7 -> 14; REM -7%2 -> 32'hFFFF_FFFF.
//  3. Back-to-back: op A completes while wb_ready=0, op B issued
//     -> fu_op_stall=1 while B ready-to-complete; raise wb_ready -> A then B, in order, no loss.
//  4. flush 5 cycles after issue -> DRAIN; fu_op_valid and operands stable until fu_op_ready;
//     no wb_valid; in_ready returns the cycle after.
//  5. flush same cycle as in_valid in IDLE -> in_ready=0, op not accepted.
//     flush same cycle as fu_op_ready -> result dropped.
//  6. TIMEOUT=8 with a stub FU that never returns ready -> err=1 at the 8th non-stalled ISSUE cycle and stays high;
//     rstn low for 1 clk -> all outputs at reset values.

Source files
------------

// File: rtl/muldiv_issue_pkg.sv
// Shared types and func3 encodings for the M-extension issue stage.
package muldiv_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_issue_if.sv
// Request/complete handshake between the issuer (master) and the
// multicycle mul/div unit (slave).
interface muldiv_issue_if #(
  parameter int XLEN = 32
);

  logic            fu_op_valid;
  logic            fu_op_ready;
  logic            fu_op_stall;
  logic [2:0]      fu_op;
  logic [XLEN-1:0] fu_op1;
  logic [XLEN-1:0] fu_op2;
  logic [XLEN-1:0] fu_op_out;

  modport master (
    output fu_op_valid, fu_op_stall, fu_op, fu_op1, fu_op2,
    input  fu_op_ready, fu_op_out
  );

  modport slave (
    input  fu_op_valid, fu_op_stall, fu_op, fu_op1, fu_op2,
    output fu_op_ready, fu_op_out
  );

endinterface

// File: rtl/muldiv_issue_wb_buf_1e.sv
// One-entry valid/ready register slice. A load and a consume in the same
// cycle replace the entry and keep it valid.
module muldiv_issue_wb_buf_1e #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic         o_free
);

  logic         r_vld_p1;
  logic [W-1:0] r_data_p1;

  // Entry register: load wins over consume so a same-cycle swap stays valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
    end else begin
      if (i_load) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= i_data;
      end else if (i_ready) begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

  assign o_valid = r_vld_p1;
  assign o_data  = r_data_p1;
  assign o_free  = ~r_vld_p1 | i_ready;

endmodule

// File: rtl/muldiv_issue.sv
// EX-stage issuer for the multicycle mul/div unit: accepts one op from
// decode, holds it on the unit handshake until completion, buffers the
// result for writeback, drains killed ops and watches for a hung unit.
module muldiv_issue
  import muldiv_issue_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int TIMEOUT = 127
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic [RD_W-1:0] in_rd,
  muldiv_issue_if.master  fu,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            err
);

  localparam int             WD_W   = $clog2(TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_op;
  logic [XLEN-1:0]      r_op1;
  logic [XLEN-1:0]      r_op2;
  logic [RD_W-1:0]      r_rd;
  logic [WD_W-1:0]      r_wdog;
  logic                 r_err;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_capture;
  logic                 w_stall;
  logic                 w_fu_valid;
  logic                 w_buf_free;
  logic [WD_W-1:0]      w_wdog_inc;
  logic [XLEN+RD_W-1:0] w_wb_q;

  // Saturating watchdog increment; holds at the timeout value.
  function automatic logic [WD_W-1:0] wdog_sat_inc(input logic [WD_W-1:0] v);
    return (v >= WD_MAX) ? v : v + 1'b1;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and handshake outputs. A full, unconsumed result buffer
  // freezes the unit so a completion can never overwrite it.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    w_fu_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = ~flush;
        if (in_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_fu_valid = 1'b1;
        w_stall    = ~w_buf_free;
        if (fu.fu_op_ready) begin
          w_capture   = ~flush;
          w_state_nxt = IDLE;
        end else if (flush) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The unit cannot abort, so the killed op runs to completion.
        w_fu_valid = 1'b1;
        if (fu.fu_op_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch: stays frozen from accept until the op leaves the unit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_op  <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_rd  <= '0;
    end else if (w_accept) begin
      r_op  <= in_op;
      r_op1 <= in_op1;
      r_op2 <= in_op2;
      r_rd  <= in_rd;
    end
  end

  assign w_wdog_inc = wdog_sat_inc(r_wdog);

  // Watchdog: counts non-stalled ISSUE/DRAIN cycles, clears on return to
  // IDLE, and latches a sticky error when it reaches the timeout.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else if (w_state_nxt == IDLE) begin
      r_wdog <= '0;
    end else if (r_state != IDLE && !w_stall) begin
      r_wdog <= w_wdog_inc;
      if (TIMEOUT != 0 && w_wdog_inc == WD_MAX) r_err <= 1'b1;
    end
  end

  muldiv_issue_wb_buf_1e #(
    .W (XLEN + RD_W)
  ) u_wb_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_capture),
    .i_data  ({r_rd, fu.fu_op_out}),
    .o_valid (wb_valid),
    .o_data  (w_wb_q),
    .i_ready (wb_ready),
    .o_free  (w_buf_free)
  );

  assign wb_rd          = w_wb_q[XLEN+RD_W-1:XLEN];
  assign wb_data        = w_wb_q[XLEN-1:0];
  assign in_ready       = w_in_ready;
  assign fu.fu_op_valid = w_fu_valid;
  assign fu.fu_op_stall = w_stall;
  assign fu.fu_op       = r_op;
  assign fu.fu_op1      = r_op1;
  assign fu.fu_op2      = r_op2;
  assign busy           = (r_state != IDLE);
  assign err            = r_err;

  // A completion with nothing outstanding means the unit is out of step.
  a_no_ready_in_idle: assert property (@(posedge clk) disable iff (!rstn)
    !(r_state == IDLE && fu.fu_op_ready));

endmodule
